// File: rtl/alu_ctrl_pkg.sv
// Shared opcode, FSM-state and owner-id definitions for the arbitrated ALU controller.
package alu_ctrl_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_SHL = 3'd2;
  localparam logic [2:0] OP_SHR = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_NOT = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/alu_core.sv
// Purely combinational 8-operation ALU; the carry/borrow output exists only when ALU_FLAGS_EN is defined.
module alu_core
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [2:0]       sel_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
`ifdef ALU_FLAGS_EN
  output logic             carry_o,
`endif
  output logic [WIDTH-1:0] y_o
);

  logic shiftOut;

  // Shift amounts at or beyond the operand width flush everything out.
  assign shiftOut = (int'(b_i) >= WIDTH);

`ifdef ALU_FLAGS_EN
  logic [WIDTH:0] sum;
  assign sum = {1'b0, a_i} + {1'b0, b_i};
`endif

  always_comb begin
    y_o = '0;
`ifdef ALU_FLAGS_EN
    carry_o = 1'b0;
`endif
    case (sel_i)
      OP_ADD: begin
`ifdef ALU_FLAGS_EN
        y_o     = sum[WIDTH-1:0];
        carry_o = sum[WIDTH];
`else
        y_o = a_i + b_i;
`endif
      end
      OP_SUB: begin
        y_o = a_i - b_i;
`ifdef ALU_FLAGS_EN
        carry_o = (a_i < b_i);
`endif
      end
      OP_SHL:  y_o = shiftOut ? '0 : (a_i << b_i);
      OP_SHR:  y_o = shiftOut ? '0 : (a_i >> b_i);
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      default: y_o = ~a_i;
    endcase
  end

endmodule

// File: rtl/alu_arbiter_controller.sv
// Arbitrates two requesters onto one shared alu_core: IDLE -> EXEC -> DONE with a registered result.
// Optional flag outputs (flag_zero, flag_carry) are enabled by defining ALU_FLAGS_EN.
module alu_arbiter_controller
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter bit FAIR  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [2:0]       sel0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [2:0]       sel1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
`ifdef ALU_FLAGS_EN
  output logic             flag_zero,
  output logic             flag_carry,
`endif
  output logic             busy
);

  state_e           state_q, state_d;
  logic             owner_q, lastOwner_q, winner, anyReq;
  logic [2:0]       sel_q;
  logic [WIDTH-1:0] a_q, b_q, result_q, aluY;
`ifdef ALU_FLAGS_EN
  logic             aluCarry, flagZero_q, flagCarry_q;
`endif

  assign anyReq = req0 | req1;

  // On contention the round-robin pointer hands the ALU to whoever was not served last.
  always_comb begin
    winner = REQ0;
    if (req0 && req1) begin
      if (FAIR) winner = (lastOwner_q == REQ0) ? REQ1 : REQ0;
    end else if (req1) begin
      winner = REQ1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (anyReq) state_d = EXEC;
      EXEC:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    done0 = 1'b0;
    done1 = 1'b0;
    busy  = (state_q != IDLE);
    if (state_q == EXEC || state_q == DONE) begin
      gnt0 = (owner_q == REQ0);
      gnt1 = (owner_q == REQ1);
    end
    if (state_q == DONE) begin
      done0 = (owner_q == REQ0);
      done1 = (owner_q == REQ1);
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_core (
    .sel_i   (sel_q),
    .a_i     (a_q),
    .b_i     (b_q),
`ifdef ALU_FLAGS_EN
    .carry_o (aluCarry),
`endif
    .y_o     (aluY)
  );

  // Operands are captured only at grant so clients may change them once granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q     <= REQ0;
      lastOwner_q <= REQ1;
      sel_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
`ifdef ALU_FLAGS_EN
      flagZero_q  <= 1'b0;
      flagCarry_q <= 1'b0;
`endif
    end else begin
      if (state_q == IDLE && anyReq) begin
        owner_q     <= winner;
        lastOwner_q <= winner;
        sel_q       <= (winner == REQ1) ? sel1 : sel0;
        a_q         <= (winner == REQ1) ? a1 : a0;
        b_q         <= (winner == REQ1) ? b1 : b0;
      end
      if (state_q == EXEC) begin
        result_q    <= aluY;
`ifdef ALU_FLAGS_EN
        flagZero_q  <= (aluY == '0);
        flagCarry_q <= aluCarry;
`endif
      end
    end
  end

  assign result = result_q;
`ifdef ALU_FLAGS_EN
  assign flag_zero  = flagZero_q;
  assign flag_carry = flagCarry_q;
`endif

endmodule

// File: tb/tb_alu_arbiter_controller.sv
// Self-checking bench for alu_arbiter_controller: directed scenarios plus randomized traffic
// scored against a behavioural arbitration/ALU model. Flag checks compile in with ALU_FLAGS_EN.
module tb_alu_arbiter_controller;
  import alu_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, fpReq0, fpReq1;
  logic [2:0] sel0, sel1;
  logic [3:0] a0, b0, a1, b1;
  logic       gnt0, gnt1, done0, done1, busy;
  logic [3:0] result;
  logic       fpGnt0, fpGnt1, fpDone0, fpDone1, fpBusy;
  logic [3:0] fpResult;
`ifdef ALU_FLAGS_EN
  logic       flagZero, flagCarry, fpFlagZero, fpFlagCarry;
`endif

  int checks = 0;
  int fails  = 0;
  int modelLast;
  logic prevDone0 = 1'b0;
  logic prevDone1 = 1'b0;

  always #5 clk = ~clk;

  alu_arbiter_controller #(.WIDTH(4), .FAIR(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .sel0(sel0), .a0(a0), .b0(b0),
    .req1(req1), .sel1(sel1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .result(result),
`ifdef ALU_FLAGS_EN
    .flag_zero(flagZero), .flag_carry(flagCarry),
`endif
    .busy(busy)
  );

  alu_arbiter_controller #(.WIDTH(4), .FAIR(1'b0)) dutFp (
    .clk(clk), .rst(rst),
    .req0(fpReq0), .sel0(sel0), .a0(a0), .b0(b0),
    .req1(fpReq1), .sel1(sel1), .a1(a1), .b1(b1),
    .gnt0(fpGnt0), .gnt1(fpGnt1), .done0(fpDone0), .done1(fpDone1), .result(fpResult),
`ifdef ALU_FLAGS_EN
    .flag_zero(fpFlagZero), .flag_carry(fpFlagCarry),
`endif
    .busy(fpBusy)
  );

  // Reference ALU written from the opcode table with plain integer arithmetic.
  function automatic logic [3:0] aluModel(input int sel, input int a, input int b);
    int r;
    case (sel)
      0: r = (a + b) % 16;
      1: r = (a - b + 16) % 16;
      2: r = (b >= 4) ? 0 : (a * (1 << b)) % 16;
      3: r = (b >= 4) ? 0 : a / (1 << b);
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      default: r = 15 - a;
    endcase
    return 4'(r);
  endfunction

  // Invariants on the fair instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      checks += 3;
      if (gnt0 && gnt1) begin
        fails++;
        $display("[TB] FAIL mutex: gnt0=%0b gnt1=%0b required not both high", gnt0, gnt1);
      end
      if ((done0 && !gnt0) || (done1 && !gnt1)) begin
        fails++;
        $display("[TB] FAIL done_gnt: done0=%0b gnt0=%0b done1=%0b gnt1=%0b", done0, gnt0, done1, gnt1);
      end
      if ((done0 && prevDone0) || (done1 && prevDone1)) begin
        fails++;
        $display("[TB] FAIL done_width: done0=%0b done1=%0b high two cycles, required one", done0, done1);
      end
    end
    prevDone0 = done0;
    prevDone1 = done1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r0, input logic [2:0] s0, input logic [3:0] x0, input logic [3:0] y0,
                               input logic r1, input logic [2:0] s1, input logic [3:0] x1, input logic [3:0] y1);
    req0 = r0; sel0 = s0; a0 = x0; b0 = y0;
    req1 = r1; sel1 = s1; a1 = x1; b1 = y1;
  endtask

  task automatic doReset;
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; fpReq0 = 1'b0; fpReq1 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    modelLast = 1;
  endtask

  // Waits (bounded) for a done pulse on the fair instance; who=-1 on timeout.
  task automatic waitDone(output int who, output logic [3:0] res, output int cycles);
    who = -1; res = 'x; cycles = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (done0 || done1) begin
        who = done1 ? 1 : 0;
        res = result;
        cycles = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    applyStimulus(1'b0, 3'd0, 4'd0, 4'd0, 1'b0, 3'd0, 4'd0, 4'd0);
    fpReq0 = 1'b0; fpReq1 = 1'b0;
    tick();
    tick();
    checks++;
    if ({busy, gnt0, gnt1, done0, done1, result} !== 9'b0) begin
      fails++;
      $display("[TB] FAIL reset_state: busy/gnt/done/result=%b required 0", {busy, gnt0, gnt1, done0, done1, result});
    end
    rst = 1'b0;
    modelLast = 1;
  endtask

  task automatic test_add_wrap;
    applyStimulus(1'b1, OP_ADD, 4'd9, 4'd8, 1'b0, 3'd0, 4'd0, 4'd0);
    tick();
    checks++;
    if (gnt0 !== 1'b1 || done0 !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL add_exec: gnt0=%0b done0=%0b busy=%0b required 1 0 1", gnt0, done0, busy);
    end
    req0 = 1'b0;
    tick();
    checks++;
    if (gnt0 !== 1'b1 || done0 !== 1'b1 || result !== 4'd1) begin
      fails++;
      $display("[TB] FAIL add_done: gnt0=%0b done0=%0b result=%0d required 1 1 1", gnt0, done0, result);
    end
`ifdef ALU_FLAGS_EN
    checks++;
    if (flagCarry !== 1'b1 || flagZero !== 1'b0) begin
      fails++;
      $display("[TB] FAIL add_flags: carry=%0b zero=%0b required 1 0", flagCarry, flagZero);
    end
`endif
    tick();
    checks++;
    if (busy !== 1'b0 || result !== 4'd1) begin
      fails++;
      $display("[TB] FAIL add_idle: busy=%0b result=%0d required 0 1 (held)", busy, result);
    end
    modelLast = 0;
  endtask

  task automatic test_arbitration_fair;
    int who, cycles, expWho;
    logic [3:0] res, expRes;
    doReset();
    applyStimulus(1'b1, OP_ADD, 4'd1, 4'd2, 1'b1, OP_XOR, 4'd5, 4'd12);
    for (int t = 0; t < 3; t++) begin
      expWho = (modelLast == 0) ? 1 : 0;
      expRes = (expWho == 0) ? aluModel(0, 1, 2) : aluModel(6, 5, 12);
      waitDone(who, res, cycles);
      checks++;
      if (who !== expWho || res !== expRes) begin
        fails++;
        $display("[TB] FAIL fair_order[%0d]: owner=%0d result=%0d required owner=%0d result=%0d", t, who, res, expWho, expRes);
      end
      checks++;
      if (cycles !== ((t == 0) ? 2 : 3)) begin
        fails++;
        $display("[TB] FAIL fair_latency[%0d]: %0d cycles required %0d", t, cycles, (t == 0) ? 2 : 3);
      end
      modelLast = expWho;
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
  endtask

  task automatic test_fixed_priority;
    int cnt0, cnt1;
    doReset();
    cnt0 = 0; cnt1 = 0;
    sel0 = OP_OR; a0 = 4'd3; b0 = 4'd4;
    fpReq0 = 1'b1; fpReq1 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (fpDone0) cnt0++;
      if (fpDone1) cnt1++;
    end
    fpReq0 = 1'b0; fpReq1 = 1'b0;
    checks++;
    if (cnt0 !== 3 || cnt1 !== 0) begin
      fails++;
      $display("[TB] FAIL fixed_prio: done0 count=%0d done1 count=%0d required 3 0", cnt0, cnt1);
    end
    checks++;
    if (fpResult !== 4'd7) begin
      fails++;
      $display("[TB] FAIL fixed_result: result=%0d required 7", fpResult);
    end
    tick();
  endtask

  task automatic test_opcode_sweep;
    logic [3:0] expTab [8] = '{4'd13, 4'd9, 4'd12, 4'd2, 4'd2, 4'd11, 4'd9, 4'd4};
    int who, cycles;
    logic [3:0] res;
    for (int op = 0; op < 10; op++) begin
      logic [3:0] bval, expRes;
      logic [2:0] s;
      s      = (op < 8) ? 3'(op) : 3'(op - 6);
      bval   = (op < 8) ? 4'd2 : 4'd5;
      expRes = (op < 8) ? expTab[op] : 4'd0;
      applyStimulus(1'b1, s, 4'b1011, bval, 1'b0, 3'd0, 4'd0, 4'd0);
      waitDone(who, res, cycles);
      req0 = 1'b0;
      checks++;
      if (who !== 0 || res !== expRes) begin
        fails++;
        $display("[TB] FAIL sweep_op%0d_b%0d: owner=%0d result=%0d required owner=0 result=%0d", s, bval, who, res, expRes);
      end
      tick();
    end
`ifdef ALU_FLAGS_EN
    applyStimulus(1'b1, OP_SUB, 4'd3, 4'd3, 1'b0, 3'd0, 4'd0, 4'd0);
    waitDone(who, res, cycles);
    req0 = 1'b0;
    checks++;
    if (res !== 4'd0 || flagZero !== 1'b1 || flagCarry !== 1'b0) begin
      fails++;
      $display("[TB] FAIL sub_zero_flag: result=%0d zero=%0b carry=%0b required 0 1 0", res, flagZero, flagCarry);
    end
    tick();
`endif
    modelLast = 0;
  endtask

  task automatic test_operand_hold;
    applyStimulus(1'b1, OP_ADD, 4'd3, 4'd5, 1'b0, 3'd0, 4'd0, 4'd0);
    tick();
    a0 = 4'd15; b0 = 4'd15; sel0 = OP_AND; req0 = 1'b0;
    tick();
    checks++;
    if (done0 !== 1'b1 || result !== 4'd8) begin
      fails++;
      $display("[TB] FAIL operand_hold: done0=%0b result=%0d required 1 8", done0, result);
    end
    tick();
    modelLast = 0;
  endtask

  task automatic test_reset_mid;
    int who, cycles;
    logic [3:0] res;
    applyStimulus(1'b1, OP_NOT, 4'd2, 4'd0, 1'b0, 3'd0, 4'd0, 4'd0);
    tick();
    rst = 1'b1; req0 = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0 || result !== 4'd0 || done0 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_mid: busy=%0b gnt0=%0b gnt1=%0b done0=%0b result=%0d required all 0", busy, gnt0, gnt1, done0, result);
    end
    rst = 1'b0;
    modelLast = 1;
    tick();
    checks++;
    if (done0 !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_no_done: done0=%0b busy=%0b required 0 0", done0, busy);
    end
    applyStimulus(1'b1, OP_XOR, 4'd5, 4'd3, 1'b0, 3'd0, 4'd0, 4'd0);
    waitDone(who, res, cycles);
    req0 = 1'b0;
    checks++;
    if (who !== 0 || res !== 4'd6 || cycles !== 2) begin
      fails++;
      $display("[TB] FAIL after_reset: owner=%0d result=%0d cycles=%0d required 0 6 2", who, res, cycles);
    end
    tick();
    modelLast = 0;
  endtask

  task automatic test_random;
    int who, cycles, expWho;
    logic [3:0] res, expRes;
    logic r0, r1;
    doReset();
    for (int n = 0; n < 40; n++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      applyStimulus(r0, 3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom),
                    r1, 3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom));
      if (r0 && r1) expWho = (modelLast == 0) ? 1 : 0;
      else          expWho = r1 ? 1 : 0;
      expRes = (expWho == 0) ? aluModel(int'(sel0), int'(a0), int'(b0))
                             : aluModel(int'(sel1), int'(a1), int'(b1));
      waitDone(who, res, cycles);
      checks++;
      if (who !== expWho || res !== expRes || cycles !== 2) begin
        fails++;
        $display("[TB] FAIL random[%0d]: owner=%0d result=%0d cycles=%0d required owner=%0d result=%0d cycles=2",
                 n, who, res, cycles, expWho, expRes);
      end
      modelLast = expWho;
      req0 = 1'b0; req1 = 1'b0;
      tick();
    end
  endtask

  initial begin
    fpReq0 = 1'b0; fpReq1 = 1'b0;
    test_reset();
    test_add_wrap();
    test_arbitration_fair();
    test_fixed_priority();
    test_opcode_sweep();
    test_operand_hold();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
